// File: rtl/ranc_pkg.sv
// Shared definitions for the RANC grid output stage.
// Holds the default packet geometry, the axon field position, an elaboration-time
// clog2 helper and a generic packet field slice function.
package ranc_pkg;

   // Default width of one column packet.
   localparam int unsigned RANC_PKT_W    = 21;
   // The axon / neuron field sits at the bottom of the packet.
   localparam int unsigned RANC_AXON_LSB = 0;
   localparam int unsigned RANC_AXON_W   = 8;

   // Ceiling log2. Used for parameter and port widths, so it must be a constant function.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   // Extract a field of 'width' bits starting at 'lsb' from a packet.
   // The packet is zero-extended to 64 bits by the caller.
   function automatic logic [31:0] field_slice(input logic [63:0] pkt,
                                               input int unsigned lsb,
                                               input int unsigned width);
      logic [63:0] mask;
      mask = (64'd1 << width) - 64'd1;
      return 32'((pkt >> lsb) & mask);
   endfunction

endpackage

// File: rtl/ranc_sync_fifo.sv
// Synchronous FIFO with show-ahead head.
// The storage is registered; data_o shows the head entry whenever the FIFO is non-empty
// and reads as zero when empty. Pointers wrap modulo DEPTH (power of two, >= 2).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push_i, data_i    write request and data (ignored when full)
//   pop_i             consume head entry (ignored when empty)
//   data_o            head entry
//   full_o, empty_o   status derived from the registered count
//   count_o           number of stored entries
module ranc_sync_fifo
   import ranc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = clog2(DEPTH),
   localparam int unsigned CW   = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   // Gate the head so stale storage never leaks out while empty.
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count decides what is visible.
   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/ranc_output_collector.sv
// Output collector for an N-column RANC core grid.
// Drains spike packets from the top row of cores with a round-robin arbiter, maps each
// packet to a global output-neuron index (column * NEURONS_PER_COL + axon), buffers the
// indices in a FIFO and presents them on a ready/valid port. Also counts accepted spikes
// per tick window and raises sticky flags for late spikes and out-of-range axons.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   tick                              one-cycle timestep pulse
//   col_packet_in, col_empty_in       show-ahead column heads and their empty flags
//   col_ren_out                       one-hot read strobe for the granted column
//   packet_out, packet_out_valid      FIFO head index and non-empty flag
//   packet_out_ready                  consumer accepts packet_out
//   tick_spike_count, tick_done       spikes in the last closed window, update pulse
//   late_spike_error, index_error     sticky error flags
module ranc_output_collector
   import ranc_pkg::*;
#(
   parameter int unsigned NUM_COLS        = 4,
   parameter int unsigned PKT_W           = RANC_PKT_W,
   parameter int unsigned AXON_W          = RANC_AXON_W,
   parameter int unsigned NEURONS_PER_COL = 250,
   parameter int unsigned FIFO_DEPTH      = 16,
   localparam int unsigned OUT_W          = clog2(NUM_COLS * NEURONS_PER_COL)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tick,
   input  logic [NUM_COLS*PKT_W-1:0] col_packet_in,
   input  logic [NUM_COLS-1:0]       col_empty_in,
   output logic [NUM_COLS-1:0]       col_ren_out,
   output logic [OUT_W-1:0]          packet_out,
   output logic                      packet_out_valid,
   input  logic                      packet_out_ready,
   output logic [15:0]               tick_spike_count,
   output logic                      tick_done,
   output logic                      late_spike_error,
   output logic                      index_error
);

   localparam int unsigned PW = (NUM_COLS > 1) ? clog2(NUM_COLS) : 1;
   localparam int unsigned CW = clog2(FIFO_DEPTH) + 1;

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [15:0]      win_q, win_d;
   logic [15:0]      count_q, count_d;
   logic             done_q, done_d;
   logic             late_q, late_d;
   logic             idx_err_q, idx_err_d;

   logic             gnt_found;
   logic [PW-1:0]    gnt_idx;
   int unsigned      cand;
   logic             grant;
   logic [PKT_W-1:0] sel_pkt;
   logic [31:0]      axon;
   logic             axon_ok;
   logic             push;
   logic [OUT_W-1:0] push_index;
   logic [15:0]      win_inc;

   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;

   // Round-robin search starting at the priority pointer.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NUM_COLS; i++) begin
         cand = (32'(ptr_q) + i) % NUM_COLS;
         if (!gnt_found && !col_empty_in[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = PW'(cand);
         end
      end
   end

   // Full is judged on the registered count only: a same-cycle pop does not open a slot.
   assign grant       = gnt_found && !fifo_full && !reset;
   assign col_ren_out = grant ? (NUM_COLS'(1) << gnt_idx) : '0;

   assign sel_pkt    = col_packet_in[gnt_idx*PKT_W +: PKT_W];
   assign axon       = field_slice(64'(sel_pkt), RANC_AXON_LSB, AXON_W);
   assign axon_ok    = (axon < NEURONS_PER_COL);
   assign push       = grant && axon_ok;
   assign push_index = OUT_W'(32'(gnt_idx) * NEURONS_PER_COL + axon);

   ranc_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (push_index),
      .pop_i   (packet_out_ready),
      .data_o  (packet_out),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign packet_out_valid = !fifo_empty;

   always_comb begin
      ptr_d     = ptr_q;
      win_inc   = win_q;
      win_d     = win_q;
      count_d   = count_q;
      done_d    = tick;
      late_d    = late_q;
      idx_err_d = idx_err_q;

      if (grant) begin
         ptr_d = PW'((32'(gnt_idx) + 1) % NUM_COLS);
      end

      if (push && (win_q != 16'hFFFF)) begin
         win_inc = win_q + 16'd1;
      end

      // A push in the tick cycle belongs to the window being closed.
      if (tick) begin
         count_d = win_inc;
         win_d   = '0;
      end else begin
         win_d = win_inc;
      end

      if (tick && ((fifo_count != '0) || (col_empty_in != '1))) begin
         late_d = 1'b1;
      end
      if (grant && !axon_ok) begin
         idx_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q     <= '0;
         win_q     <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         late_q    <= 1'b0;
         idx_err_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         count_q   <= count_d;
         done_q    <= done_d;
         late_q    <= late_d;
         idx_err_q <= idx_err_d;
      end
   end

   assign tick_spike_count = count_q;
   assign tick_done        = done_q;
   assign late_spike_error = late_q;
   assign index_error      = idx_err_q;

endmodule

// File: tb/tb_ranc_output_collector.sv
// Bench for ranc_output_collector: column buffer model, directed stimulus and a
// scoreboard (expected read strobes and output indices) checked by a monitor.
module tb_ranc_output_collector;

   localparam int NC = 4;
   localparam int PW = 21;
   localparam int OW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          tick;
   logic [NC*PW-1:0] col_packet_in;
   logic [NC-1:0] col_empty_in;
   logic [NC-1:0] col_ren_out;
   logic [OW-1:0] packet_out;
   logic          packet_out_valid;
   logic          packet_out_ready;
   logic [15:0]   tick_spike_count;
   logic          tick_done;
   logic          late_spike_error;
   logic          index_error;

   int            checks = 0;
   int            errors = 0;
   int            ren_total = 0;

   int            exp_data[$];
   logic [NC-1:0] exp_ren[$];

   logic [PW-1:0] colmem [NC][64];
   int            hd [NC];
   int            tl [NC];
   logic [NC-1:0] ren_seen = '0;

   always #5 clk = ~clk;

   ranc_output_collector dut (
      .clk              (clk),
      .reset            (reset),
      .tick             (tick),
      .col_packet_in    (col_packet_in),
      .col_empty_in     (col_empty_in),
      .col_ren_out      (col_ren_out),
      .packet_out       (packet_out),
      .packet_out_valid (packet_out_valid),
      .packet_out_ready (packet_out_ready),
      .tick_spike_count (tick_spike_count),
      .tick_done        (tick_done),
      .late_spike_error (late_spike_error),
      .index_error      (index_error)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic refresh();
      for (int c = 0; c < NC; c++) begin
         col_empty_in[c]           = (hd[c] == tl[c]);
         col_packet_in[c*PW +: PW] = colmem[c][hd[c] % 64];
      end
   endtask

   // Upper packet bits carry junk so only the axon field may influence the index.
   task automatic col_load(input int c, input int axon);
      logic [PW-1:0] pkt;
      pkt = PW'(axon & 8'hFF) | (PW'(c + 5) << 13);
      colmem[c][tl[c] % 64] = pkt;
      tl[c]++;
      refresh();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick  = 1'b0;
      step();
      for (int c = 0; c < NC; c++) begin
         hd[c] = 0;
         tl[c] = 0;
      end
      refresh();
      exp_data.delete();
      exp_ren.delete();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_data.size() != 0 || exp_ren.size() != 0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (exp_data.size() != 0 || exp_ren.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d data and %0d strobes outstanding, expected 0",
                  name, exp_data.size(), exp_ren.size());
      end
   endtask

   // Column buffers consume their head when the strobe was seen in the previous cycle.
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < NC; c++) begin
         if (ren_seen[c] && hd[c] != tl[c]) hd[c]++;
      end
      refresh();
   end

   // Monitor: compares every strobe and every accepted output against the scoreboard.
   always @(negedge clk) begin
      logic [NC-1:0] er;
      int            ed;
      ren_seen = col_ren_out;
      if (col_ren_out != '0) begin
         ren_total++;
         if (exp_ren.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ren_unexpected: got %b, expected no strobe", col_ren_out);
         end else begin
            er = exp_ren.pop_front();
            check("ren_order", int'(col_ren_out), int'(er));
         end
      end
      if (!reset && packet_out_valid && packet_out_ready) begin
         if (exp_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL data_unexpected: got %0d, expected no output", packet_out);
         end else begin
            ed = exp_data.pop_front();
            check("data", int'(packet_out), ed);
         end
      end
   end

   initial begin
      int base;
      reset            = 1'b1;
      tick             = 1'b0;
      packet_out_ready = 1'b0;
      for (int c = 0; c < NC; c++) begin
         hd[c] = 0;
         tl[c] = 0;
      end
      refresh();
      step();
      step();

      // Reset state
      check("rst_ren", int'(col_ren_out), 0);
      check("rst_packet_out", int'(packet_out), 0);
      check("rst_valid", int'(packet_out_valid), 0);
      check("rst_count", int'(tick_spike_count), 0);
      check("rst_done", int'(tick_done), 0);
      check("rst_late", int'(late_spike_error), 0);
      check("rst_index", int'(index_error), 0);
      reset = 1'b0;

      // Single spike: column 2, axon 7 -> 2*250+7
      packet_out_ready = 1'b1;
      exp_ren.push_back(4'b0100);
      exp_data.push_back(507);
      col_load(2, 7);
      @(negedge clk);
      check("single_ren", int'(col_ren_out), 4);
      step();
      check("single_valid", int'(packet_out_valid), 1);
      check("single_index", int'(packet_out), 507);
      step();
      check("single_popped", int'(packet_out_valid), 0);

      // Round robin: 3 packets per column
      do_reset();
      packet_out_ready = 1'b1;
      base = ren_total;
      for (int j = 0; j < 3; j++) begin
         for (int c = 0; c < NC; c++) begin
            col_load(c, 10 * j + c);
            exp_ren.push_back(NC'(1 << c));
            exp_data.push_back(c * 250 + 10 * j + c);
         end
      end
      wait_drain("rr", 100);
      check("rr_strobes", ren_total - base, 12);

      // Backpressure: 20 packets into a 16-entry FIFO
      do_reset();
      packet_out_ready = 1'b0;
      base = ren_total;
      for (int i = 0; i < 20; i++) begin
         col_load(0, i * 3);
         exp_ren.push_back(4'b0001);
         exp_data.push_back(i * 3);
      end
      repeat (25) step();
      check("full_strobes", ren_total - base, 16);
      check("full_valid", int'(packet_out_valid), 1);
      check("full_head", int'(packet_out), 0);
      packet_out_ready = 1'b1;
      @(negedge clk);
      check("full_no_grant_on_pop", int'(col_ren_out), 0);
      wait_drain("drain", 100);
      check("drain_strobes", ren_total - base, 20);

      // Bad index: axon 250 on column 1 is consumed and dropped
      do_reset();
      packet_out_ready = 1'b1;
      exp_ren.push_back(4'b0010);
      col_load(1, 250);
      step();
      step();
      check("bad_index_flag", int'(index_error), 1);
      check("bad_index_nopush", int'(packet_out_valid), 0);
      exp_ren.push_back(4'b0010);
      exp_data.push_back(499);
      col_load(1, 249);
      wait_drain("edge_index", 50);
      check("bad_index_sticky", int'(index_error), 1);

      // Tick accounting: tick coincides with the 6th push
      do_reset();
      packet_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         col_load(0, i);
         exp_ren.push_back(4'b0001);
         exp_data.push_back(i);
      end
      repeat (5) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("tick_done_pulse", int'(tick_done), 1);
      check("tick_count6", int'(tick_spike_count), 6);
      step();
      check("tick_done_low", int'(tick_done), 0);
      check("tick_count_hold", int'(tick_spike_count), 6);
      wait_drain("tick", 50);
      tick = 1'b1;
      step();
      check("tick_empty_done", int'(tick_done), 1);
      check("tick_count0", int'(tick_spike_count), 0);
      step();
      tick = 1'b0;
      check("tick_b2b_done", int'(tick_done), 1);
      step();
      check("tick_b2b_low", int'(tick_done), 0);

      // Late spike: tick while two entries wait in the FIFO
      do_reset();
      packet_out_ready = 1'b0;
      col_load(0, 3);
      col_load(0, 4);
      exp_ren.push_back(4'b0001);
      exp_ren.push_back(4'b0001);
      exp_data.push_back(3);
      exp_data.push_back(4);
      repeat (3) step();
      check("late_before", int'(late_spike_error), 0);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("late_set", int'(late_spike_error), 1);
      check("late_count", int'(tick_spike_count), 2);
      step();
      check("late_sticky", int'(late_spike_error), 1);
      packet_out_ready = 1'b1;
      step();
      // Reset mid-drain with a column presenting a packet
      reset = 1'b1;
      col_load(3, 9);
      @(negedge clk);
      check("rst_mid_ren", int'(col_ren_out), 0);
      step();
      check("rst_mid_packet_out", int'(packet_out), 0);
      check("rst_mid_valid", int'(packet_out_valid), 0);
      check("rst_mid_count", int'(tick_spike_count), 0);
      check("rst_mid_done", int'(tick_done), 0);
      check("rst_mid_late", int'(late_spike_error), 0);
      check("rst_mid_index", int'(index_error), 0);
      exp_data.delete();
      exp_ren.push_back(4'b1000);
      exp_data.push_back(759);
      reset = 1'b0;
      wait_drain("post_reset", 50);
      step();
      check("final_empty", int'(packet_out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
